if_stage: RTL

- Instruction-fetch stage of the RV32I pipeline: owns the PC, issues single-outstanding requests to instruction memory, and drives the IF/ID pipeline register.
- Consumes the stall controls `pcwrite` / `ifid_write` produced by the hazard detection unit, plus the branch redirect from EX.
- Inserts bubbles (NOP, valid low) on memory wait, on branch flush and after reset.

---
 rtl/rv32i_pkg.sv | 15 +
 rtl/if_stage_ifid_reg.sv | 57 +++++
 rtl/if_stage.sv | 166 ++++++++++++++++
 3 files changed

// File: rtl/rv32i_pkg.sv
// Shared RV32I pipeline definitions: datapath width, bubble encoding,
// reset fetch address and the instruction-fetch state encoding.
package rv32i_pkg;

  localparam int          XLEN      = 32;
  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;  // addi x0,x0,0
  localparam logic [31:0] RESET_PC  = 32'h0000_0000;

  typedef enum logic [1:0] {
    IDLE = 2'd0,  // no request outstanding
    WAIT = 2'd1,  // request granted, response pending
    HOLD = 2'd2   // response captured, waiting for IF/ID to accept it
  } fetch_state_e;

endpackage

// File: rtl/if_stage_ifid_reg.sv
// IF/ID pipeline register. Priority: flush > hold > load > bubble.
// A flush or a bubble replaces the instruction with NOP and clears valid,
// but keeps the previous PC fields so ID always sees a stable PC.
module ifid_reg #(
  parameter int          XLEN      = rv32i_pkg::XLEN,
  parameter logic [31:0] NOP_INSTR = rv32i_pkg::NOP_INSTR
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            flush_i,
  input  logic            hold_i,
  input  logic            load_i,
  input  logic [XLEN-1:0] pc_i,
  input  logic [31:0]     instr_i,
  output logic [XLEN-1:0] pc_o,
  output logic [XLEN-1:0] pc_plus4_o,
  output logic [31:0]     instr_o,
  output logic            valid_o
);

  logic [XLEN-1:0] pc_q;
  logic [XLEN-1:0] pc_plus4_q;
  logic [31:0]     instr_q;
  logic            valid_q;

  // Pipeline register update: flush, hold, load or bubble.
  // NOTE: state is written with non-blocking assignments so every register
  // samples the values from before the clock edge, regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q       <= '0;
      pc_plus4_q <= '0;
      instr_q    <= NOP_INSTR;
      valid_q    <= 1'b0;
    end else if (flush_i) begin
      instr_q <= NOP_INSTR;
      valid_q <= 1'b0;
    end else if (hold_i) begin
      instr_q <= instr_q;
      valid_q <= valid_q;
    end else if (load_i) begin
      pc_q       <= pc_i;
      pc_plus4_q <= pc_i + XLEN'(4);
      instr_q    <= instr_i;
      valid_q    <= 1'b1;
    end else begin
      instr_q <= NOP_INSTR;
      valid_q <= 1'b0;
    end
  end

  assign pc_o       = pc_q;
  assign pc_plus4_o = pc_plus4_q;
  assign instr_o    = instr_q;
  assign valid_o    = valid_q;

endmodule

// File: rtl/if_stage.sv
// RV32I instruction-fetch stage: owns the PC, issues one outstanding
// instruction-memory request at a time and feeds the IF/ID register.
// The PC advances only when a response is consumed by IF/ID.
// Optional macro IF_STAGE_PERF_EN adds perf_fetched / perf_bubbles counters.
module if_stage #(
  parameter int              XLEN      = rv32i_pkg::XLEN,
  parameter logic [XLEN-1:0] RESET_PC  = rv32i_pkg::RESET_PC,
  parameter logic [31:0]     NOP_INSTR = rv32i_pkg::NOP_INSTR
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            pcwrite,
  input  logic            ifid_write,
  input  logic            branch_taken,
  input  logic [XLEN-1:0] branch_target,
  output logic            imem_req,
  output logic [XLEN-1:0] imem_addr,
  input  logic            imem_gnt,
  input  logic            imem_rvalid,
  input  logic [31:0]     imem_rdata,
  output logic [XLEN-1:0] pc_id,
  output logic [XLEN-1:0] pc_plus4_id,
  output logic [31:0]     instr_id,
  output logic            valid_id
`ifdef IF_STAGE_PERF_EN
  ,
  output logic [31:0]     perf_fetched,
  output logic [31:0]     perf_bubbles
`endif
);

  import rv32i_pkg::*;

  fetch_state_e    state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic            drop_q, drop_d;
  logic [31:0]     buf_q, buf_d;

  logic            ifid_flush;
  logic            ifid_hold;
  logic            ifid_load;
  logic [31:0]     ifid_instr;

  // Redirect targets are word addresses; the low bits are simply discarded.
  logic unused_tgt_bits;
  assign unused_tgt_bits = &{1'b0, branch_target[1:0]};

  // A request is only issued from IDLE, never while reset is asserted.
  assign imem_req  = rst_n && (state_q == IDLE) && pcwrite;
  assign imem_addr = pc_q;

  // Next-state logic for the fetch FSM, PC, drop flag and hold buffer.
  // NOTE: every signal driven here gets a default first so no path leaves
  // it unassigned, which would otherwise infer a latch.
  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    drop_d     = drop_q;
    buf_d      = buf_q;
    ifid_flush = 1'b0;
    ifid_hold  = !ifid_write;
    ifid_load  = 1'b0;
    ifid_instr = (state_q == HOLD) ? buf_q : imem_rdata;

    if (branch_taken) begin
      // Redirect wins over any stall; whatever is in flight becomes stale.
      pc_d       = {branch_target[XLEN-1:2], 2'b00};
      ifid_flush = 1'b1;
      unique case (state_q)
        IDLE: if (imem_req && imem_gnt) begin
          state_d = WAIT;
          drop_d  = 1'b1;
        end
        WAIT: if (imem_rvalid) begin
          state_d = IDLE;
          drop_d  = 1'b0;
        end else begin
          drop_d  = 1'b1;
        end
        HOLD: state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end else begin
      unique case (state_q)
        IDLE: if (imem_req && imem_gnt) state_d = WAIT;
        WAIT: if (imem_rvalid) begin
          if (drop_q) begin
            state_d = IDLE;
            drop_d  = 1'b0;
          end else if (ifid_write) begin
            ifid_load = 1'b1;
            if (pcwrite) pc_d = pc_q + XLEN'(4);
            state_d = IDLE;
          end else begin
            buf_d   = imem_rdata;
            state_d = HOLD;
          end
        end
        HOLD: if (ifid_write) begin
          ifid_load = 1'b1;
          if (pcwrite) pc_d = pc_q + XLEN'(4);
          state_d = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // Fetch FSM state registers.
  // NOTE: the one-entry hold buffer is reset too; it is a single register,
  // not a RAM, so clearing it costs nothing and keeps X out of IF/ID.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      pc_q    <= RESET_PC;
      drop_q  <= 1'b0;
      buf_q   <= NOP_INSTR;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      drop_q  <= drop_d;
      buf_q   <= buf_d;
    end
  end

  // While in WAIT or HOLD the PC still names the fetched instruction.
  ifid_reg #(
    .XLEN      (XLEN),
    .NOP_INSTR (NOP_INSTR)
  ) u_ifid_reg (
    .clk        (clk),
    .rst_n      (rst_n),
    .flush_i    (ifid_flush),
    .hold_i     (ifid_hold),
    .load_i     (ifid_load),
    .pc_i       (pc_q),
    .instr_i    (ifid_instr),
    .pc_o       (pc_id),
    .pc_plus4_o (pc_plus4_id),
    .instr_o    (instr_id),
    .valid_o    (valid_id)
  );

`ifdef IF_STAGE_PERF_EN
  logic [31:0] perf_fetched_q;
  logic [31:0] perf_bubbles_q;
  logic        bubble_load;

  assign bubble_load = ifid_flush || (!ifid_hold && !ifid_load);

  // Free-running wrap-around counters of real and bubble IF/ID loads.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_fetched_q <= '0;
      perf_bubbles_q <= '0;
    end else begin
      if (ifid_load && !ifid_flush) perf_fetched_q <= perf_fetched_q + 32'd1;
      if (bubble_load)              perf_bubbles_q <= perf_bubbles_q + 32'd1;
    end
  end

  assign perf_fetched = perf_fetched_q;
  assign perf_bubbles = perf_bubbles_q;
`endif

endmodule
